boot_loader: RTL and testbench

Instruction-memory boot loader and fetch port for the vector processor core. It accepts a length-prefixed, checksummed word stream over a valid/ready handshake and writes it into a 256×32 instruction store. It holds the core in boot (`boot_up` high) until a load passes its checksum. It then serves the core's combinational instruction fetch (`IF_PC` → `instn`), sitting directly upstream of the IF stage and the IF/ID register.

---
 rtl/boot_loader_if.sv | 20 ++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Boot-stream handshake between the image source (master) and the boot loader (slave).
interface boot_loader_if #(
    parameter int DW = 32
);
    logic          start;
    logic [8:0]    boot_len;
    logic          boot_valid;
    logic [DW-1:0] boot_data;
    logic          boot_ready;

    modport master (
        output start, boot_len, boot_valid, boot_data,
        input  boot_ready
    );

    modport slave (
        input  start, boot_len, boot_valid, boot_data,
        output boot_ready
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: fills the instruction store from a checksummed word stream and
// serves the core's combinational instruction fetch once an image has passed.
module boot_loader #(
    parameter int DEPTH = 256,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    boot_loader_if.slave      bus,
    output logic              boot_up,
    output logic              done,
    output logic              load_err,
    output logic [8:0]        words_loaded,
    input  logic [15:0]       IF_PC,
    output logic [DW-1:0]     instn
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [8:0]    cnt_r;
    logic [8:0]    len_r;
    logic [8:0]    len_s;
    logic [DW-1:0] sum_r;
    logic          loaded_r;
    logic          done_r;
    logic          load_err_r;
    logic          accept_s;
    logic          pc_unused_s;
    logic [DW-1:0] mem [0:DEPTH-1];

    // Oversized requests are clamped to the store depth.
    assign len_s        = (bus.boot_len > 9'd256) ? 9'd256 : bus.boot_len;
    assign bus.boot_ready = (state_r != IDLE);
    assign accept_s     = bus.boot_valid & bus.boot_ready;
    assign boot_up      = (state_r != IDLE) | ~loaded_r;
    assign done         = done_r;
    assign load_err     = load_err_r;
    assign words_loaded = cnt_r;
    assign pc_unused_s  = ^IF_PC[1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = (len_s != 9'd0) ? LOAD : CSUM;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && ((cnt_r + 9'd1) == len_r)) begin
                    state_s = CSUM;
                end else begin
                    state_s = LOAD;
                end
            end
            CSUM: begin
                if (accept_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = CSUM;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Load bookkeeping: counters, running checksum, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 9'd0;
            len_r      <= 9'd0;
            sum_r      <= {DW{1'b0}};
            loaded_r   <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        len_r      <= len_s;
                        cnt_r      <= 9'd0;
                        sum_r      <= {DW{1'b0}};
                        load_err_r <= 1'b0;
                        loaded_r   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        sum_r <= sum_r + bus.boot_data;
                        cnt_r <= cnt_r + 9'd1;
                    end
                end
                CSUM: begin
                    if (accept_s) begin
                        load_err_r <= (bus.boot_data != sum_r);
                        loaded_r   <= (bus.boot_data == sum_r);
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                    loaded_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((state_r == LOAD) && accept_s) begin
            mem[cnt_r[AW-1:0]] <= bus.boot_data;
        end
    end

    // Fetch port: zero while held in boot or outside the 1 KiB window.
    always_comb begin
        instn = {DW{1'b0}};
        if (boot_up || (IF_PC[15:10] != 6'd0)) begin
            instn = {DW{1'b0}};
        end else begin
            instn = mem[IF_PC[AW+1:2]];
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: drives on the falling edge, checks on the falling edge.
module tb_boot_loader;
    logic        clk;
    logic        rst_n;
    logic        boot_up;
    logic        done;
    logic        load_err;
    logic [8:0]  words_loaded;
    logic [15:0] IF_PC;
    logic [31:0] instn;
    int          vec_cnt;
    int          err_cnt;

    boot_loader_if #(.DW(32)) bif ();

    boot_loader #(.DEPTH(256), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bif.slave),
        .boot_up      (boot_up),
        .done         (done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .IF_PC        (IF_PC),
        .instn        (instn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; start is seen by the next rising edge.
    task automatic do_start(input logic [8:0] len);
        bif.start    = 1'b1;
        bif.boot_len = len;
        @(negedge clk);
        bif.start    = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        bif.boot_valid = 1'b1;
        bif.boot_data  = d;
        while (bif.boot_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bif.boot_ready !== 1'b1) begin
            check_vec("ready_timeout", {31'd0, bif.boot_ready}, 32'd1);
        end
        @(negedge clk);
        bif.boot_valid = 1'b0;
        bif.boot_data  = $urandom;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        rst_n          = 1'b0;
        bif.start      = 1'b0;
        bif.boot_len   = 9'd0;
        bif.boot_valid = 1'b0;
        bif.boot_data  = 32'd0;
        IF_PC          = 16'd0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif.start      = 1'($urandom_range(0, 1));
            bif.boot_len   = 9'($urandom);
            bif.boot_valid = 1'($urandom_range(0, 1));
            bif.boot_data  = $urandom;
            IF_PC          = 16'($urandom);
        end
        #1;
        check_vec("rst_boot_up", {31'd0, boot_up}, 32'd1);
        check_vec("rst_ready", {31'd0, bif.boot_ready}, 32'd0);
        check_vec("rst_done", {31'd0, done}, 32'd0);
        check_vec("rst_load_err", {31'd0, load_err}, 32'd0);
        check_vec("rst_words", {23'd0, words_loaded}, 32'd0);
        check_vec("rst_instn", instn, 32'd0);
        @(negedge clk);
        bif.start      = 1'b0;
        bif.boot_valid = 1'b0;
        rst_n          = 1'b1;
        gap(2);
        check_vec("post_rst_boot_up", {31'd0, boot_up}, 32'd1);
        check_vec("post_rst_ready", {31'd0, bif.boot_ready}, 32'd0);
        check_vec("post_rst_done", {31'd0, done}, 32'd0);
        check_vec("post_rst_instn", instn, 32'd0);

        // Good load with valid gaps
        do_start(9'd4);
        check_vec("good_ready", {31'd0, bif.boot_ready}, 32'd1);
        send_word(32'h11); gap(1);
        send_word(32'h22);
        send_word(32'h33); gap(2);
        send_word(32'h44);
        check_vec("good_words_csum", {23'd0, words_loaded}, 32'd4);
        send_word(32'hAA);
        check_vec("good_done", {31'd0, done}, 32'd1);
        check_vec("good_err", {31'd0, load_err}, 32'd0);
        check_vec("good_boot_up", {31'd0, boot_up}, 32'd0);
        check_vec("good_words", {23'd0, words_loaded}, 32'd4);
        IF_PC = 16'h0008; #1;
        check_vec("good_fetch_8", instn, 32'h33);
        IF_PC = 16'h000B; #1;
        check_vec("good_fetch_b", instn, 32'h33);
        IF_PC = 16'h0000; #1;
        check_vec("good_fetch_0", instn, 32'h11);
        IF_PC = 16'h0400; #1;
        check_vec("good_fetch_oob", instn, 32'h0);

        // Bad checksum, start issued in the done cycle
        do_start(9'd4);
        check_vec("bad_done_gone", {31'd0, done}, 32'd0);
        check_vec("bad_started", {31'd0, bif.boot_ready}, 32'd1);
        check_vec("bad_hold", {31'd0, boot_up}, 32'd1);
        IF_PC = 16'h0008; #1;
        check_vec("bad_load_instn", instn, 32'h0);
        send_word(32'h11);
        send_word(32'h22);
        send_word(32'h33);
        send_word(32'h44);
        send_word(32'hAB);
        check_vec("bad_done", {31'd0, done}, 32'd1);
        check_vec("bad_err", {31'd0, load_err}, 32'd1);
        check_vec("bad_boot_up", {31'd0, boot_up}, 32'd1);
        #1;
        check_vec("bad_instn", instn, 32'h0);
        gap(2);
        check_vec("bad_err_sticky", {31'd0, load_err}, 32'd1);
        check_vec("bad_done_pulse", {31'd0, done}, 32'd0);
        do_start(9'd4);
        check_vec("rerun_err_clr", {31'd0, load_err}, 32'd0);
        send_word(32'h11);
        send_word(32'h22);
        send_word(32'h33);
        send_word(32'h44);
        send_word(32'hAA);
        check_vec("rerun_err", {31'd0, load_err}, 32'd0);
        check_vec("rerun_boot_up", {31'd0, boot_up}, 32'd0);
        gap(1);

        // Zero length
        do_start(9'd0);
        check_vec("zero_ready", {31'd0, bif.boot_ready}, 32'd1);
        send_word(32'h0);
        check_vec("zero_done", {31'd0, done}, 32'd1);
        check_vec("zero_err", {31'd0, load_err}, 32'd0);
        check_vec("zero_boot_up", {31'd0, boot_up}, 32'd0);
        check_vec("zero_words", {23'd0, words_loaded}, 32'd0);
        gap(1);
        do_start(9'd0);
        send_word(32'h5);
        check_vec("zero_bad_done", {31'd0, done}, 32'd1);
        check_vec("zero_bad_err", {31'd0, load_err}, 32'd1);
        check_vec("zero_bad_boot_up", {31'd0, boot_up}, 32'd1);
        gap(1);

        // Full store with clamped length and an ignored mid-load start
        do_start(9'd300);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                bif.start    = 1'b1;
                bif.boot_len = 9'd2;
            end
            send_word(32'(i));
            bif.start = 1'b0;
            if (i == 127) begin
                check_vec("full_words_mid", {23'd0, words_loaded}, 32'd128);
            end
        end
        check_vec("full_words", {23'd0, words_loaded}, 32'd256);
        check_vec("full_csum_ready", {31'd0, bif.boot_ready}, 32'd1);
        send_word(32'h7F80);
        check_vec("full_done", {31'd0, done}, 32'd1);
        check_vec("full_err", {31'd0, load_err}, 32'd0);
        check_vec("full_boot_up", {31'd0, boot_up}, 32'd0);
        IF_PC = 16'h03FC; #1;
        check_vec("full_fetch_top", instn, 32'hFF);
        IF_PC = 16'h0200; #1;
        check_vec("full_fetch_mid", instn, 32'h80);
        gap(1);

        // Reset mid-load, then a fresh load
        do_start(9'd4);
        IF_PC = 16'h03FC; #1;
        check_vec("loading_instn_zero", instn, 32'h0);
        send_word(32'h1);
        send_word(32'h2);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_boot_up", {31'd0, boot_up}, 32'd1);
        check_vec("mid_rst_ready", {31'd0, bif.boot_ready}, 32'd0);
        check_vec("mid_rst_words", {23'd0, words_loaded}, 32'd0);
        check_vec("mid_rst_instn", instn, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        gap(1);
        check_vec("mid_rst_idle", {31'd0, bif.boot_ready}, 32'd0);
        do_start(9'd4);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        send_word(32'h4);
        send_word(32'hA);
        check_vec("fresh_done", {31'd0, done}, 32'd1);
        check_vec("fresh_err", {31'd0, load_err}, 32'd0);
        check_vec("fresh_boot_up", {31'd0, boot_up}, 32'd0);
        IF_PC = 16'h0004; #1;
        check_vec("fresh_fetch", instn, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
